// File: rtl/spi_read_sequencer.sv
// Command/readback sequencer in front of spi_master: one command byte, up to four
// dummy bytes, received bytes packed right-justified into rdata, framed by cs_n.
module spi_read_sequencer #(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  cmd,
    input  logic [2:0]  len,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic        cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [7:0]  spi_rx,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  cmd_q;
    logic [2:0]  len_q;

    logic accept;
    logic cnt_clr;
    logic cnt_inc;
    logic capture;
    logic idx_inc;
    logic abort;
    logic hold_end;
    logic to_hit;

    // One counter serves setup, per-byte timeout (WAIT+DRAIN) and hold phases.
    assign to_hit = (cnt >= TO_LAST);

    // Handshake: a transaction is accepted on any edge where ready=1 and req=1;
    // req is ignored while ready=0. done pulses once per accepted transaction.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        idx_inc    = 1'b0;
        abort      = 1'b0;
        hold_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = S_SEND;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_SEND: begin
                cnt_clr    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // new_data beats a coinciding timeout so the byte is not lost
                if (spi_new_data) begin
                    capture    = (idx != 3'd0);
                    cnt_inc    = 1'b1;
                    state_next = S_DRAIN;
                end else if (to_hit) begin
                    abort      = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!spi_busy) begin
                    if (idx == len_q) begin
                        cnt_clr    = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = S_SEND;
                    end
                end else if (to_hit) begin
                    abort      = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    hold_end   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            idx   <= 3'd0;
            cmd_q <= 8'h00;
            len_q <= 3'd0;
            rdata <= 32'd0;
            error <= 1'b0;
            cs_n  <= 1'b1;
        end else begin
            state <= state_next;
            if (cnt_clr) begin
                cnt <= 16'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 16'd1;
            end
            if (accept) begin
                cmd_q <= cmd;
                len_q <= (len > 3'd4) ? 3'd4 : len;
                rdata <= 32'd0;
                error <= 1'b0;
                cs_n  <= 1'b0;
                idx   <= 3'd0;
            end
            if (capture) begin
                rdata <= {rdata[23:0], spi_rx};
            end
            if (idx_inc) begin
                idx <= idx + 3'd1;
            end
            if (abort) begin
                error <= 1'b1;
            end
            if (hold_end) begin
                cs_n <= 1'b1;
            end
        end
    end

    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign spi_start = (state == S_SEND);
    assign spi_data  = (state == S_SEND && idx == 3'd0) ? cmd_q : 8'h00;
    assign fsm_state = state;

endmodule

// File: doc/spi_read_sequencer.md
# spi_read_sequencer

Command/readback sequencer that sits directly upstream of `spi_master` and drives its `start`/`data_in` inputs. It also consumes that block's `busy`/`new_data`/`data_out` outputs. On a request it:
- drops chip select;
- shifts out one command byte, then N dummy bytes;
- assembles the N received bytes into a right-justified 32-bit word, releases chip select and pulses `done`.

It replaces `test_constants_spi` as the SPI stimulus source, for sensor register reads. It runs in the `spi_master` clock domain.

## Interface
- `CS_SETUP`, default 4: clocks from `cs_n` fall to first `spi_start`; legal range 1..255.
- `CS_HOLD`, default 4: clocks from last byte complete to `cs_n` rise; legal range 1..255.
- `TIMEOUT`, default 1024: maximum clocks spent waiting on `spi_master` per byte; legal range 2..65535.

- `clk`  in  1  single clock, same as `spi_master.clk`.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  start transaction; sampled only when `ready`=1.
- `cmd`  in  8  command byte, latched on accept.
- `len`  in  3  read byte count, latched on accept; 0 = command only; values >4 clamp to 4.
- `ready`  out  1  idle, accepting `req`.
- `done`  out  1  one-cycle pulse at transaction end.
- `error`  out  1  valid with `done`: 1 = timeout abort.
- `rdata`  out  32  received bytes, right-justified.
- `cs_n`  out  1  active-low chip select.
- `spi_start`  out  1  to `spi_master.start`; one-cycle pulse.
- `spi_data`  out  8  to `spi_master.data_in`; valid while `spi_start`=1.
- `spi_busy`  in  1  from `spi_master.busy`.
- `spi_new_data`  in  1  from `spi_master.new_data`.
- `spi_rx`  in  8  from `spi_master.data_out`.

## Operation
- Reset values:
  - `ready`=1, `done`=0, `error`=0, `rdata`=0, `cs_n`=1, `spi_start`=0, `spi_data`=0x00.
  - State is IDLE; byte index `idx`=0.
- IDLE: `ready`=1. On `req`=1, at the same edge:
  - latch `cmd` and `len` (clamped);
  - clear `rdata` and `error`;
  - set `cs_n`=0 and `idx`=0, then go to SETUP.
- SETUP: count `CS_SETUP` cycles, then go to SEND.
- SEND: assert `spi_start`=1 for exactly one cycle.
  - `spi_data` = latched `cmd` when `idx`=0, otherwise 0x00.
  - Clear the timeout counter and go to WAIT.
- WAIT: wait for `spi_new_data`=1.
  - If `idx`>0, set `rdata` <= {`rdata`[23:0], `spi_rx`}. The `idx`=0 (command-phase) byte is discarded.
  - Then go to DRAIN.
- DRAIN: wait for `spi_busy`=0.
  - If `idx`==`len`, go to HOLD.
  - Otherwise increment `idx` and go to SEND.
- Timeout: the counter runs in WAIT+DRAIN combined. On reaching `TIMEOUT`, set `error`=1 and go to HOLD; `rdata` keeps the bytes received so far.
- HOLD: keep `cs_n`=0 for `CS_HOLD` cycles, then `cs_n`=1 and go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Outputs in every non-IDLE state: `ready`=0; `req` is ignored.
- `rdata`/`error` hold their value from DONE until the next accepted `req`.
- Byte order: the first received byte is the most significant of the used bytes. Example: `len`=2 with rx A5, 3C gives `rdata`=0x0000A53C.
- `rst` mid-transaction: at the next edge, all outputs return to their reset values, including `cs_n`=1 and `spi_start`=0. No `done` is pulsed.

## Timing
- Transaction start: `cs_n` falls on the edge that accepts `req`. The first `spi_start` is high in the cycle `CS_SETUP` clocks later.
- Between bytes: the next `spi_start` is high in the cycle after the one where `spi_busy`=0 is sampled in DRAIN.
- Transaction end, counted from the cycle `spi_busy`=0 is sampled for the last byte:
  - `cs_n` rises `CS_HOLD`+1 clocks later;
  - `done` is high in that same cycle;
  - `ready`=1 the cycle after.
- Simultaneous `spi_new_data` and timeout expiry in WAIT: `spi_new_data` wins; the byte is captured.
- If `spi_busy` is already 0 when DRAIN is entered, DRAIN lasts one cycle.
- A `req` held high through DONE starts the next transaction on the first IDLE edge. `cs_n` is then high for at least 1 cycle between transactions.
- `spi_start` is never asserted while `cs_n`=1.

## Test plan
- Bench setup: behavioural `spi_master` model with `busy` = 8 SCK × N clocks and `new_data` pulsed 1 cycle before `busy` falls. Parameters at defaults unless stated.
- `len`=2, `cmd`=0x8F, model rx = 0x00, 0xA5, 0x3C -> `spi_data` sequence is 0x8F, 0x00, 0x00 and `rdata`=0x0000A53C. Also check: `error`=0, exactly 1 `done` pulse, 3 `spi_start` pulses.
- `len`=0, `cmd`=0x06 -> 1 `spi_start`, `rdata`=0, `done` with `error`=0. Check setup/hold gaps: first `spi_start` 4 clocks after `cs_n` fall, `cs_n` rise 5 clocks after last busy-low.
- `len`=7, rx bytes 11, 22, 33, 44 -> clamped to 4 reads: 5 `spi_start` pulses, `rdata`=0x11223344.
- Model stops asserting `new_data` after the command byte, `TIMEOUT`=16 -> `error`=1, `done` pulse, `cs_n`=1; `ready` returns within 16+`CS_HOLD`+3 clocks of the stall.
- `rst` asserted while in WAIT of byte 2 -> next edge shows `cs_n`=1, `ready`=1, `rdata`=0, and no `done` pulse. A following `req` with `len`=1 completes normally.
- `req` pulsed while `ready`=0, and `spi_new_data` coinciding with timeout expiry -> the extra `req` is ignored and the coinciding byte is captured with `error`=0.
